// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch-stage PC generator.
// RVC_EN selects 2-byte (compressed) instead of 4-byte alignment.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } pc_state_e;

    localparam logic [1:0] ALIGN_MASK_RVC = 2'b01;
    localparam logic [1:0] ALIGN_MASK_STD = 2'b11;

`ifdef RVC_EN
    localparam logic [1:0] ALIGN_MASK = ALIGN_MASK_RVC;
`else
    localparam logic [1:0] ALIGN_MASK = ALIGN_MASK_STD;
`endif

    function automatic logic addr_misaligned(input logic [1:0] low_bits);
        return |(low_bits & ALIGN_MASK);
    endfunction

endpackage

// File: rtl/pc_redirect_arb.sv
// Next-PC source select (trap > branch/jump > pending > sequential) and
// alignment check of the redirect target. Alignment depends on RVC_EN.
module pc_redirect_arb
    import pc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            trap,
    input  logic [XLEN-1:0] trap_vec,
    input  logic            j_br,
    input  logic [XLEN-1:0] bta,
    input  logic            pend_valid,
    input  logic [XLEN-1:0] pend_addr,
    input  logic [XLEN-1:0] seq_addr,
    output logic [XLEN-1:0] target,
    output logic            redir_valid,
    output logic            redir_is_trap,
    output logic            misaligned
);

    // Priority select of the fetch target
    always_comb begin
        target        = seq_addr;
        redir_valid   = 1'b0;
        redir_is_trap = 1'b0;
        if (trap) begin
            target        = trap_vec;
            redir_valid   = 1'b1;
            redir_is_trap = 1'b1;
        end else if (j_br) begin
            target      = bta;
            redir_valid = 1'b1;
        end else if (pend_valid) begin
            target = pend_addr;
        end else begin
            target = seq_addr;
        end
    end

    // Pending addresses were checked on capture, so only fresh redirects can fault
    assign misaligned = redir_valid & addr_misaligned(target[1:0]);

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program counter generator with imem ready handshake and
// pending redirect capture. Optional feature macro: RVC_EN.
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = {XLEN{1'b0}},
    parameter int              INC_BYTES = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            trap,
    input  logic [XLEN-1:0] trap_vec,
    input  logic            j_br,
    input  logic [XLEN-1:0] bta,
    input  logic            imem_ready,
    input  logic            is_rvc,
    output logic            imem_req,
    output logic [XLEN-1:0] pc_if,
    output logic [XLEN-1:0] pc_next,
    output logic            misalign_fault
);

    pc_state_e       state_r, state_s;
    logic [XLEN-1:0] pc_r, pc_s;
    logic [XLEN-1:0] pend_addr_r, pend_addr_s;
    logic            pend_valid_r, pend_valid_s;
    logic            pend_is_trap_r, pend_is_trap_s;
    logic            fault_r, fault_s;
    logic [XLEN-1:0] inc_s, seq_addr_s, target_s;
    logic            redir_s, redir_trap_s, misaligned_s;

`ifdef RVC_EN
    assign inc_s = is_rvc ? XLEN'(2'd2) : XLEN'(INC_BYTES);
`else
    logic unused_is_rvc_s;
    assign unused_is_rvc_s = is_rvc;
    assign inc_s           = XLEN'(INC_BYTES);
`endif

    assign seq_addr_s = stall ? pc_r : (pc_r + inc_s);

    pc_redirect_arb #(
        .XLEN(XLEN)
    ) u_arb (
        .trap          (trap),
        .trap_vec      (trap_vec),
        .j_br          (j_br),
        .bta           (bta),
        .pend_valid    (pend_valid_r),
        .pend_addr     (pend_addr_r),
        .seq_addr      (seq_addr_s),
        .target        (target_s),
        .redir_valid   (redir_s),
        .redir_is_trap (redir_trap_s),
        .misaligned    (misaligned_s)
    );

    // Next-state, PC and pending-slot update
    always_comb begin
        state_s        = state_r;
        pc_s           = pc_r;
        pend_addr_s    = pend_addr_r;
        pend_valid_s   = pend_valid_r;
        pend_is_trap_s = pend_is_trap_r;
        fault_s        = 1'b0;
        case (state_r)
            BOOT: begin
                state_s = RUN;
            end
            RUN, PEND: begin
                if (redir_s && misaligned_s) begin
                    fault_s = 1'b1;
                end else if (imem_ready) begin
                    pc_s           = target_s;
                    pend_valid_s   = 1'b0;
                    pend_is_trap_s = 1'b0;
                    state_s        = RUN;
                end else if (redir_s && ((state_r == RUN) || redir_trap_s || !pend_is_trap_r)) begin
                    // A queued trap may only be displaced by another trap
                    pend_addr_s    = target_s;
                    pend_valid_s   = 1'b1;
                    pend_is_trap_s = redir_trap_s;
                    state_s        = PEND;
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s        = BOOT;
                pend_valid_s   = 1'b0;
                pend_is_trap_s = 1'b0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r        <= BOOT;
            pc_r           <= RESET_VEC;
            pend_addr_r    <= {XLEN{1'b0}};
            pend_valid_r   <= 1'b0;
            pend_is_trap_r <= 1'b0;
            fault_r        <= 1'b0;
        end else begin
            state_r        <= state_s;
            pc_r           <= pc_s;
            pend_addr_r    <= pend_addr_s;
            pend_valid_r   <= pend_valid_s;
            pend_is_trap_r <= pend_is_trap_s;
            fault_r        <= fault_s;
        end
    end

    assign imem_req       = (state_r != BOOT) & ~stall;
    assign pc_if          = pc_r;
    assign pc_next        = target_s;
    assign misalign_fault = fault_r;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed vector table, hand-written
// reset/RVC sequences and a randomized run against a behavioural model.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        reset, stall, trap, j_br, imem_ready, is_rvc;
    logic [31:0] trap_vec, bta;
    logic        imem_req, misalign_fault;
    logic [31:0] pc_if, pc_next;

    int n_checks = 0;
    int n_fail   = 0;

    pc_gen #(
        .XLEN      (32),
        .RESET_VEC (32'h0000_0100),
        .INC_BYTES (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .trap           (trap),
        .trap_vec       (trap_vec),
        .j_br           (j_br),
        .bta            (bta),
        .imem_ready     (imem_ready),
        .is_rvc         (is_rvc),
        .imem_req       (imem_req),
        .pc_if          (pc_if),
        .pc_next        (pc_next),
        .misalign_fault (misalign_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        trap;
        logic [31:0] tv;
        logic        jbr;
        logic [31:0] bta;
        logic        rdy;
        logic        stall;
        logic        exp_req;
        logic [31:0] exp_pc;
        logic        exp_fault;
    } vec_t;

    vec_t tbl[21];

`ifdef RVC_EN
    localparam logic [31:0] BAD_ADDR = 32'h0000_2001;
`else
    localparam logic [31:0] BAD_ADDR = 32'h0000_2002;
`endif

    // behavioural model state
    logic        m_boot, m_pend_v, m_pend_trap, m_fault;
    logic [31:0] m_pc, m_pend_a;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic t, input logic [31:0] tv, input logic j,
                                input logic [31:0] b, input logic r, input logic s,
                                input logic req, input logic [31:0] pc, input logic f);
        vec_t v;
        v.trap = t; v.tv = tv; v.jbr = j; v.bta = b; v.rdy = r; v.stall = s;
        v.exp_req = req; v.exp_pc = pc; v.exp_fault = f;
        return v;
    endfunction

    function automatic logic bad_align(input logic [31:0] a);
`ifdef RVC_EN
        return a[0];
`else
        return a[1:0] != 2'b00;
`endif
    endfunction

    task automatic drive(input logic t, input logic [31:0] tv, input logic j,
                         input logic [31:0] b, input logic r, input logic s, input logic rv);
        trap = t; trap_vec = tv; j_br = j; bta = b; imem_ready = r; stall = s; is_rvc = rv;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        m_boot = 1'b1; m_pc = 32'h100; m_pend_v = 1'b0; m_pend_a = 32'h0;
        m_pend_trap = 1'b0; m_fault = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One model-checked cycle; called just after a falling edge
    task automatic rstep(input logic t, input logic [31:0] tv, input logic j,
                         input logic [31:0] b, input logic r, input logic s, input logic rv);
        logic [31:0] tgt, cand, inc;
        logic        redir, bad;
        drive(t, tv, j, b, r, s, rv);
        redir = t | j;
        tgt   = t ? tv : b;
        inc   = 32'd4;
`ifdef RVC_EN
        if (rv) inc = 32'd2;
`endif
        if (redir)         cand = tgt;
        else if (m_pend_v) cand = m_pend_a;
        else if (s)        cand = m_pc;
        else               cand = m_pc + inc;
        bad = redir && bad_align(tgt);
        #1;
        chk("rnd_pc_next", pc_next, cand);
        chk("rnd_imem_req", {31'd0, imem_req}, {31'd0, (!m_boot && !s)});
        @(posedge clk);
        m_fault = !m_boot && bad;
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (!bad) begin
            if (r) begin
                m_pc = cand; m_pend_v = 1'b0;
            end else if (redir && (!m_pend_v || t || !m_pend_trap)) begin
                m_pend_v = 1'b1; m_pend_a = tgt; m_pend_trap = t;
            end
        end
        #1;
        chk("rnd_pc_if", pc_if, m_pc);
        chk("rnd_fault", {31'd0, misalign_fault}, {31'd0, m_fault});
        @(negedge clk);
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        a = $urandom;
        if ($urandom_range(7) != 0) a[1:0] = 2'b00;
        return a;
    endfunction

    initial begin
        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        //           trap tv            jbr  bta            rdy  stall req  pc             fault
        tbl[0]  = mk(1'b0, 32'h0,       1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h100,      1'b0);
        tbl[1]  = mk(1'b0, 32'h0,       1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h104,      1'b0);
        tbl[2]  = mk(1'b0, 32'h0,       1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h108,      1'b0);
        tbl[3]  = mk(1'b0, 32'h0,       1'b1, 32'h2000,     1'b0, 1'b0, 1'b1, 32'h108,      1'b0);
        tbl[4]  = mk(1'b0, 32'h0,       1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h108,      1'b0);
        tbl[5]  = mk(1'b0, 32'h0,       1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h108,      1'b0);
        tbl[6]  = mk(1'b0, 32'h0,       1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h2000,     1'b0);
        tbl[7]  = mk(1'b0, 32'h0,       1'b1, 32'h3000,     1'b0, 1'b0, 1'b1, 32'h2000,     1'b0);
        tbl[8]  = mk(1'b1, 32'h80,      1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h2000,     1'b0);
        tbl[9]  = mk(1'b0, 32'h0,       1'b1, 32'h4000,     1'b0, 1'b0, 1'b1, 32'h2000,     1'b0);
        tbl[10] = mk(1'b0, 32'h0,       1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h80,       1'b0);
        tbl[11] = mk(1'b0, 32'h0,       1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h84,       1'b0);
        tbl[12] = mk(1'b0, 32'h0,       1'b1, BAD_ADDR,     1'b1, 1'b0, 1'b1, 32'h84,       1'b1);
        tbl[13] = mk(1'b0, 32'h0,       1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h88,       1'b0);
        tbl[14] = mk(1'b0, 32'h0,       1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        tbl[15] = mk(1'b0, 32'h0,       1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h0,        1'b0);
        tbl[16] = mk(1'b0, 32'h0,       1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        1'b0);
        tbl[17] = mk(1'b0, 32'h0,       1'b1, 32'h40,       1'b1, 1'b1, 1'b0, 32'h40,       1'b0);
        tbl[18] = mk(1'b1, 32'h200,     1'b1, 32'h300,      1'b1, 1'b0, 1'b1, 32'h200,      1'b0);
        tbl[19] = mk(1'b1, 32'h81,      1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h200,      1'b1);
        tbl[20] = mk(1'b0, 32'h0,       1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h204,      1'b0);

        // reset state
        #12;
        chk("reset_pc_if", pc_if, 32'h100);
        chk("reset_imem_req", {31'd0, imem_req}, 32'd0);
        chk("reset_fault", {31'd0, misalign_fault}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // directed table
        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].trap, tbl[i].tv, tbl[i].jbr, tbl[i].bta, tbl[i].rdy, tbl[i].stall, 1'b0);
            #1;
            chk($sformatf("tbl%0d_imem_req", i), {31'd0, imem_req}, {31'd0, tbl[i].exp_req});
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_pc_if", i), pc_if, tbl[i].exp_pc);
            chk($sformatf("tbl%0d_fault", i), {31'd0, misalign_fault}, {31'd0, tbl[i].exp_fault});
            @(negedge clk);
        end

        // reset asserted while a redirect is pending
        drive(1'b0, 32'h0, 1'b1, 32'h5000, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("pend_hold_pc_if", pc_if, 32'h204);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_pc_if", pc_if, 32'h100);
        chk("async_reset_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        imem_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_boot_pc", pc_if, 32'h100);
        @(posedge clk);
        #1;
        chk("post_reset_pend_dropped", pc_if, 32'h104);
        @(negedge clk);

`ifdef RVC_EN
        drive(1'b0, 32'h0, 1'b1, 32'h10, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("rvc_jump_pc", pc_if, 32'h10);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk("rvc_step_pc", pc_if, 32'h12);
        @(negedge clk);
`endif

        // randomized run against the model
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            rstep($urandom_range(9) == 0, rnd_addr(),
                  $urandom_range(6) == 0, rnd_addr(),
                  $urandom_range(9) < 7, $urandom_range(4) == 0,
                  $urandom_range(1) == 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
